// File: rtl/wbpipemem.sv
// wbpipemem: pipelined Wishbone (B4 pipelined) memory slave.
//
// A word-addressed RAM sits behind a fixed-latency response pipeline. An
// outstanding-request counter throttles the bus through o_wb_stall.
// Addresses outside the BASE window complete with o_wb_err instead of ack.
//
// Ports:
//   i_clk       system clock
//   i_rst       synchronous, active-high reset
//   i_wb_cyc    bus cycle; dropping it aborts every outstanding request
//   i_wb_stb    request strobe
//   i_wb_we     write enable
//   i_wb_addr   word address, AW bits
//   i_wb_data   write data
//   i_wb_sel    byte selects, bit 3 selects bits 31:24
//   o_wb_stall  request not accepted this cycle
//   o_wb_ack    successful completion, one pulse per accepted request
//   o_wb_err    bus error completion for an out-of-window access
//   o_wb_data   read data, valid with o_wb_ack, 0 with o_wb_err
//
// Parameters:
//   AW       word-address width
//   LGMEMSZ  log2 of the RAM size in 32-bit words
//   BASE     value of i_wb_addr[AW-1:LGMEMSZ] that selects this RAM
//   LATENCY  cycles from acceptance to ack/err, 1..8
//   MAXOUT   maximum outstanding requests, 1..LATENCY
module wbpipemem #(
    parameter int unsigned AW      = 30,
    parameter int unsigned LGMEMSZ = 15,
    parameter int unsigned BASE    = 1,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned MAXOUT  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic [31:0]   o_wb_data
);

    localparam int unsigned CW = $clog2(MAXOUT + 1);
    localparam int unsigned TW = AW - LGMEMSZ;
    localparam logic [TW-1:0] BaseTag = TW'(BASE);
    localparam logic [CW-1:0] MaxCnt  = CW'(MAXOUT);

    // Storage; deliberately never reset.
    logic [31:0] mem [2**LGMEMSZ];

    logic               accept;
    logic               in_win;
    logic               retire;
    logic [LGMEMSZ-1:0] idx;

    // Response pipeline: index 0 is loaded at acceptance, LATENCY-1 drives the bus.
    logic [LATENCY-1:0] vld_q, vld_d;
    logic [LATENCY-1:0] err_q, err_d;
    logic [31:0]        data_q [LATENCY];

    logic [CW-1:0] cnt_q, cnt_d;

    // Last data presented with a response, so o_wb_data holds between acks.
    logic [31:0] hold_q;

    assign in_win = (i_wb_addr[AW-1:LGMEMSZ] == BaseTag);
    assign idx    = i_wb_addr[LGMEMSZ-1:0];

    // Ungated retire keeps stall a function of registered state only; when
    // i_wb_cyc is low nothing can be accepted anyway.
    assign retire     = vld_q[LATENCY-1];
    assign o_wb_stall = (cnt_q == MaxCnt) && !retire;
    assign accept     = i_wb_cyc && i_wb_stb && !o_wb_stall;

    // An abort (or reset) in the retire cycle suppresses the response.
    assign o_wb_ack  = i_wb_cyc && !i_rst && retire && !err_q[LATENCY-1];
    assign o_wb_err  = i_wb_cyc && !i_rst && retire && err_q[LATENCY-1];
    assign o_wb_data = (o_wb_ack || o_wb_err) ? data_q[LATENCY-1] : hold_q;

    always_comb begin
        vld_d    = '0;
        err_d    = '0;
        vld_d[0] = accept;
        err_d[0] = accept && !in_win;
        for (int i = 1; i < int'(LATENCY); i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
        end
    end

    // Net zero when a request is accepted in the same cycle one retires.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && !retire) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept && retire) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_wb_cyc) begin
            vld_q <= '0;
            err_q <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q <= '0;
        end else if (o_wb_ack || o_wb_err) begin
            hold_q <= data_q[LATENCY-1];
        end
    end

    // Byte-lane writes happen in the acceptance cycle.
    always_ff @(posedge i_clk) begin
        if (accept && i_wb_we && in_win) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wb_sel[b]) begin
                    mem[idx][8*b +: 8] <= i_wb_data[8*b +: 8];
                end
            end
        end
    end

    // Reads sample the RAM at the acceptance edge; a write accepted on the
    // previous edge is already committed, so read-after-write sees new data.
    // Writes and errors carry zero data.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            data_q[0] <= (in_win && !i_wb_we) ? mem[idx] : '0;
        end
        for (int i = 1; i < int'(LATENCY); i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

endmodule

// File: tb/tb_wbpipemem.sv
module tb_wbpipemem;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;

    logic [2:0]  stall_w, ack_w, err_w;
    logic [31:0] rdata_w [3];

    always #5 clk = ~clk;

    // Three configurations share the bus inputs; dsel picks the one observed.
    int lat_p [3] = '{2, 4, 3};
    int mo_p  [3] = '{2, 2, 3};

    wbpipemem #(.LATENCY(2), .MAXOUT(2)) u_l2 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall_w[0]),
        .o_wb_ack(ack_w[0]), .o_wb_err(err_w[0]), .o_wb_data(rdata_w[0])
    );
    wbpipemem #(.LATENCY(4), .MAXOUT(2)) u_l4 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall_w[1]),
        .o_wb_ack(ack_w[1]), .o_wb_err(err_w[1]), .o_wb_data(rdata_w[1])
    );
    wbpipemem #(.LATENCY(3), .MAXOUT(3)) u_l3 (
        .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_stall(stall_w[2]),
        .o_wb_ack(ack_w[2]), .o_wb_err(err_w[2]), .o_wb_data(rdata_w[2])
    );

    typedef struct {
        bit          err;
        bit          rd;
        bit          chk;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mdl [int];

    int          checks = 0;
    int          failures = 0;
    int          dsel = 0;
    int          cyc_no = 0;
    int          ack_cnt = 0;
    int          err_cnt = 0;
    int          stall_cnt = 0;
    int          first_ack = 0;
    int          last_ack = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit inwin(input logic [29:0] a);
        return a[29:15] == 15'd1;
    endfunction

    function automatic int key(input int d, input logic [29:0] a);
        return d * 32768 + int'(a[14:0]);
    endfunction

    // Samples the current cycle mid-period, scores responses, then moves to
    // just after the next rising edge.
    task automatic tick(output bit acc);
        exp_t        e;
        logic [31:0] m;
        bit          exp_stall;
        acc = 1'b0;
        #4;
        cyc_no++;
        if (rst) begin
            sb.delete();
        end else if (!cyc) begin
            chk("abort_ack", 32'(ack_w[dsel]), 32'd0);
            chk("abort_err", 32'(err_w[dsel]), 32'd0);
            sb.delete();
        end else begin
            exp_stall = (sb.size() == mo_p[dsel]) && !(sb.size() > 0 && sb[0].due == cyc_no);
            chk("stall", 32'(stall_w[dsel]), 32'(exp_stall));
            if (stb && stall_w[dsel]) stall_cnt++;
            if (ack_w[dsel] || err_w[dsel]) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'({ack_w[dsel], err_w[dsel]}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_err", 32'(err_w[dsel]), 32'(e.err));
                    chk("resp_ack", 32'(ack_w[dsel]), 32'(!e.err));
                    chk("resp_latency", cyc_no, e.due);
                    if (e.err) chk("err_data", rdata_w[dsel], 32'd0);
                    else if (e.rd && e.chk) chk("rd_data", rdata_w[dsel], e.data);
                    if (ack_w[dsel] && e.rd) last_rd = rdata_w[dsel];
                end
                if (ack_w[dsel]) begin
                    if (ack_cnt == 0) first_ack = cyc_no;
                    last_ack = cyc_no;
                    ack_cnt++;
                end
                if (err_w[dsel]) err_cnt++;
            end else if (sb.size() > 0 && sb[0].due <= cyc_no) begin
                chk("missing_resp", 32'd0, 32'd1);
                void'(sb.pop_front());
            end
            acc = stb && !stall_w[dsel];
            if (acc) begin
                e.err = !inwin(addr);
                e.rd  = !we;
                e.chk = mdl.exists(key(dsel, addr)) && !$isunknown(mdl[key(dsel, addr)]);
                e.data = e.chk ? mdl[key(dsel, addr)] : 32'd0;
                e.due = cyc_no + lat_p[dsel];
                sb.push_back(e);
                chk("outstanding_le_max", 32'(sb.size() <= mo_p[dsel]), 32'd1);
            end
            for (int d = 0; d < 3; d++) begin
                if (stb && !stall_w[d] && we && inwin(addr)) begin
                    m = mdl.exists(key(d, addr)) ? mdl[key(d, addr)] : 32'hx;
                    for (int b = 0; b < 4; b++) if (sel[b]) m[8*b +: 8] = wdata[8*b +: 8];
                    mdl[key(d, addr)] = m;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        stb = 1'b0;
        for (int i = 0; i < n; i++) tick(acc);
    endtask

    // Holds stb until accepted; leaves stb high so successive calls stream.
    task automatic req(input bit w, input logic [29:0] a, input logic [31:0] d,
                       input logic [3:0] s, output int acc_at);
        bit acc = 1'b0;
        stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        acc_at = -1;
        for (int n = 0; n < 40; n++) begin
            tick(acc);
            if (acc) begin
                acc_at = cyc_no;
                break;
            end
        end
        chk("req_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        bit acc;
        stb = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (sb.size() == 0) break;
            tick(acc);
        end
        chk("drain_empty", sb.size(), 32'd0);
        tick(acc);
        tick(acc);
    endtask

    initial begin
        int a;
        int acc_at [8];
        int base_ack;
        int base_err;

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; sel = '0;
        idle(2);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_stall", 32'(stall_w[d]), 32'd0);
            chk("rst_ack", 32'(ack_w[d]), 32'd0);
            chk("rst_err", 32'(err_w[d]), 32'd0);
            chk("rst_data", rdata_w[d], 32'd0);
        end

        // Write/read back, LATENCY=2.
        cyc = 1'b1;
        dsel = 0;
        idle(1);
        last_rd = '0;
        req(1'b1, 30'h8004, 32'hDEADBEEF, 4'hF, a);
        req(1'b0, 30'h8004, 32'h0, 4'h0, a);
        drain();
        chk("wr_rd_data", last_rd, 32'hDEADBEEF);

        // Byte lanes.
        last_rd = '0;
        req(1'b1, 30'h8010, 32'h11223344, 4'hF, a);
        req(1'b1, 30'h8010, 32'hAABBCCDD, 4'h5, a);
        req(1'b0, 30'h8010, 32'h0, 4'h0, a);
        drain();
        chk("byte_lanes", last_rd, 32'h11BB33DD);

        // Out of window.
        base_ack = ack_cnt;
        base_err = err_cnt;
        req(1'b0, 30'h10004, 32'h0, 4'h0, a);
        req(1'b1, 30'h10004, 32'h12345678, 4'hF, a);
        drain();
        chk("oow_err_count", err_cnt - base_err, 32'd2);
        chk("oow_no_ack", ack_cnt - base_ack, 32'd0);
        last_rd = '0;
        req(1'b0, 30'h8004, 32'h0, 4'h0, a);
        drain();
        chk("oow_ram_intact", last_rd, 32'hDEADBEEF);

        // Throttle, LATENCY=4 MAXOUT=2.
        dsel = 1;
        base_ack = ack_cnt;
        for (int i = 0; i < 8; i++) req(1'b1, 30'h8040 + 30'(i), 32'h100 + 32'(i), 4'hF, acc_at[i]);
        drain();
        chk("thr_2nd_accept", acc_at[1] - acc_at[0], 32'd1);
        chk("thr_3rd_accept", acc_at[2] - acc_at[0], 32'd4);
        chk("thr_4th_accept", acc_at[3] - acc_at[0], 32'd5);
        chk("thr_ack_count", ack_cnt - base_ack, 32'd8);
        for (int i = 0; i < 8; i++) req(1'b0, 30'h8040 + 30'(i), 32'h0, 4'h0, a);
        drain();
        chk("thr_last_read", last_rd, 32'h107);

        // Full rate, LATENCY=MAXOUT=3.
        dsel = 2;
        for (int i = 0; i < 16; i++) req(1'b1, 30'h8100 + 30'(i), 32'hA5000000 + 32'(i), 4'hF, a);
        drain();
        stall_cnt = 0;
        ack_cnt = 0;
        for (int i = 0; i < 16; i++) req(1'b0, 30'h8100 + 30'(i), 32'h0, 4'h0, a);
        drain();
        chk("full_no_stall", stall_cnt, 32'd0);
        chk("full_ack_count", ack_cnt, 32'd16);
        chk("full_ack_span", last_ack - first_ack, 32'd15);
        chk("full_last_read", last_rd, 32'hA500000F);

        // Abort with two outstanding.
        dsel = 0;
        req(1'b1, 30'h8020, 32'hCAFEF00D, 4'hF, a);
        req(1'b0, 30'h8004, 32'h0, 4'h0, a);
        stb = 1'b0;
        cyc = 1'b0;
        idle(3);
        chk("abort_stall_low", 32'(stall_w[dsel]), 32'd0);
        cyc = 1'b1;
        base_ack = ack_cnt;
        idle(5);
        chk("abort_no_late_ack", ack_cnt - base_ack, 32'd0);
        last_rd = '0;
        req(1'b0, 30'h8020, 32'h0, 4'h0, a);
        drain();
        chk("abort_write_kept", last_rd, 32'hCAFEF00D);

        // Reset with two outstanding.
        req(1'b1, 30'h8030, 32'h0BADC0DE, 4'hF, a);
        req(1'b0, 30'h8004, 32'h0, 4'h0, a);
        stb = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("rst_mid_stall", 32'(stall_w[dsel]), 32'd0);
        chk("rst_mid_ack", 32'(ack_w[dsel]), 32'd0);
        chk("rst_mid_data", rdata_w[dsel], 32'd0);
        base_ack = ack_cnt;
        base_err = err_cnt;
        idle(5);
        chk("rst_no_late_ack", ack_cnt - base_ack, 32'd0);
        chk("rst_no_late_err", err_cnt - base_err, 32'd0);
        last_rd = '0;
        req(1'b0, 30'h8030, 32'h0, 4'h0, a);
        drain();
        chk("rst_ram_kept_a", last_rd, 32'h0BADC0DE);
        last_rd = '0;
        req(1'b0, 30'h8020, 32'h0, 4'h0, a);
        drain();
        chk("rst_ram_kept_b", last_rd, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wbpipemem.md
# wbpipemem

Pipelined Wishbone (B4 pipelined) memory slave with configurable acknowledgement latency, outstanding-request throttling and bus-error generation for out-of-window addresses. It sits directly downstream of the `zipmmu` master port in the MMU bench and in small SoCs. It replaces a plain RAM plus an ad-hoc error register, so the MMU can be exercised against realistic multi-cycle, back-pressured memory.

## Interface
- `AW`, 30: word-address width of the bus.
- `LGMEMSZ`, 15: log2 of RAM size in 32-bit words.
- `BASE`, 1: required value of `i_wb_addr[AW-1:LGMEMSZ]` for an in-window access.
- `LATENCY`, 2: cycles from request acceptance to ack/err; legal range 1..8.
- `MAXOUT`, 2: maximum outstanding requests; legal range 1..`LATENCY`.

Ports:
- `i_clk`, in, 1: system clock.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_wb_cyc`, in, 1: bus cycle.
- `i_wb_stb`, in, 1: request strobe.
- `i_wb_we`, in, 1: write enable.
- `i_wb_addr`, in, `AW`: word address.
- `i_wb_data`, in, 32: write data.
- `i_wb_sel`, in, 4: byte selects; bit 3 selects bits 31:24.
- `o_wb_stall`, out, 1: request not accepted this cycle.
- `o_wb_ack`, out, 1: successful completion.
- `o_wb_err`, out, 1: bus error completion.
- `o_wb_data`, out, 32: read data, valid with `o_wb_ack`.

## Operation
- Accept: a request is accepted when `i_wb_cyc && i_wb_stb && !o_wb_stall`. A strobe without `i_wb_cyc` is ignored and never acknowledged.
- In window: the address is in window when `i_wb_addr[AW-1:LGMEMSZ] == BASE`. The RAM index is `i_wb_addr[LGMEMSZ-1:0]`.
- Accepted in-window write: updates only the selected bytes in the acceptance cycle. `sel=0` writes nothing but is still acked.
- Accepted in-window read: reads RAM at acceptance. A read accepted in the cycle after a write to the same word returns the new data.
- Accepted out-of-window access: produces `o_wb_err` instead of ack. There is no RAM write and the response data is 0.
- Response pipeline: `LATENCY` register stages, each carrying {valid, err, data}. Stage 1 loads at acceptance, stages shift every cycle, and the last stage drives the outputs. Responses are never reordered.
- Outstanding counter, width `clog2(MAXOUT+1)`:
  - +1 on accept, −1 on ack/err, net 0 when both happen in the same cycle.
  - `o_wb_stall = (count == MAXOUT) && !(o_wb_ack || o_wb_err)`. A retiring response frees its slot in the same cycle.
- Abort: when `i_wb_cyc` is low, all pipeline valid bits and the counter clear on the next edge, and no further ack/err is issued for the aborted requests. Writes already accepted remain in RAM.
- `o_wb_data` holds its last value when no ack is present. `o_wb_data` is 0 with err.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `o_wb_stall=0`, `o_wb_ack=0`, `o_wb_err=0`, `o_wb_data=0`, counter 0, all pipeline valid bits 0.
- Reset mid-operation: all outstanding responses are dropped, with no ack/err after reset.
- Latency: a request accepted on edge N produces ack/err high during the cycle after edge N+`LATENCY`−1, i.e. `LATENCY`=1 acks in the next cycle.
- `o_wb_ack` and `o_wb_err` are never high together. Each is a one-cycle pulse per accepted request.
- Throughput:
  - With `MAXOUT`=`LATENCY`, the block sustains one request per cycle with no stall.
  - With `MAXOUT`<`LATENCY`, a continuous stream stalls, giving `MAXOUT` accepts per `LATENCY` cycles.
- Stall is combinational from registered state only; it does not depend on `i_wb_stb`.
- Simultaneous abort and retire: abort wins, so ack is suppressed if `i_wb_cyc` is low in that cycle.

## Test plan
- Write/read back with `LATENCY`=2: write 0xDEADBEEF to word address 0x8004 (BASE=1, LGMEMSZ=15), `sel`=0xF, then read 0x8004 → ack exactly 2 cycles after each acceptance and read data 0xDEADBEEF.
- Byte lanes: write 0x11223344 with `sel`=0xF, then 0xAABBCCDD with `sel`=0x5, then read → 0x11BB33DD.
- Out of window: read 0x10004 → `o_wb_err` pulse at latency 2, data 0, no ack. A following write to 0x10004 does not alter RAM word 0x0004.
- Throttle with `LATENCY`=4, `MAXOUT`=2, `stb` held high for 8 requests:
  - Required pattern: accept, accept, then stall until the first ack.
  - Exactly 8 acks, in order.
  - Counter never exceeds 2.
- Full rate with `LATENCY`=`MAXOUT`=3: 16 back-to-back reads → `o_wb_stall` never high, 16 consecutive ack cycles.
- Abort and reset:
  - Drop `i_wb_cyc` with 2 requests outstanding → no ack/err afterwards, `o_wb_stall`=0, and a new cycle acks normally.
  - Repeat with `i_rst` instead of the cyc drop → same result, and the RAM still holds prior writes.
